beat_sequencer: RTL

- Beat/timing sequencer for the hardwired-controller CPU.
- Generates the one-hot beat vector W[3:1] consumed by the instruction controller.
- Honours the controller's SHORT/LONG/STOP requests at beat boundaries.
- Provides run/halt control from the console start button QD, plus a single-step mode.

---
 rtl/beat_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/beat_sequencer.sv
// Beat/timing sequencer: one-hot W[3:1] beats on falling T3, QD start with synchroniser, single-step.
// Optional live cycle counter on CYC_CNT when BEAT_SEQ_CYC_CNT_EN is defined (otherwise tied to zero).
module beat_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        T3,
    input  logic        CLR,
    input  logic        QD,
    input  logic        STEP,
    input  logic        SHORT,
    input  logic        LONG,
    input  logic        STOP,
    output logic [3:1]  W,
    output logic        RUN,
    output logic        CYC_END,
    output logic [15:0] CYC_CNT
);

    // State encoding doubles as the beat vector, so W comes straight from the state flops.
    typedef enum logic [2:0] {
        HALT = 3'b000,
        S_W1 = 3'b001,
        S_W2 = 3'b010,
        S_W3 = 3'b100
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] qd_sync;
    logic                   qd_prev;
    logic                   start;
    logic                   stop_pend;
    logic                   cyc_end;
    logic                   halt_req;

    assign start    = qd_sync[SYNC_STAGES-1] & ~qd_prev;
    assign halt_req = stop_pend | STOP | STEP;

    always_comb begin
        cyc_end = 1'b0;
        case (state)
            S_W1:    cyc_end = SHORT;
            S_W2:    cyc_end = ~LONG;
            S_W3:    cyc_end = 1'b1;
            default: cyc_end = 1'b0;
        endcase
    end

    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            qd_sync <= '0;
            qd_prev <= 1'b0;
        end else begin
            qd_sync <= {qd_sync[SYNC_STAGES-2:0], QD};
            qd_prev <= qd_sync[SYNC_STAGES-1];
        end
    end

    // A start pulse is only honoured in HALT; one seen while running is simply dropped.
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            state     <= HALT;
            stop_pend <= 1'b0;
        end else if (state == HALT) begin
            if (start)
                state <= S_W1;
        end else if (cyc_end) begin
            state     <= halt_req ? HALT : S_W1;
            stop_pend <= 1'b0;
        end else begin
            state <= (state == S_W1) ? S_W2 : S_W3;
            if (STOP)
                stop_pend <= 1'b1;
        end
    end

`ifdef BEAT_SEQ_CYC_CNT_EN
    logic [15:0] cyc_cnt;

    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR)
            cyc_cnt <= 16'h0000;
        else if (cyc_end)
            cyc_cnt <= cyc_cnt + 16'h0001;
    end

    assign CYC_CNT = cyc_cnt;
`else
    assign CYC_CNT = 16'h0000;
`endif

    assign W       = state;
    assign RUN     = |state;
    assign CYC_END = cyc_end;

endmodule
